// File: rtl/debounce_bank_if.sv
// debounce_bank_if: signal bundle between the debouncer bank and its user.
//   threshold - shared stability threshold (extra stable cycles)
//   in        - raw asynchronous channel inputs
//   ack       - per-channel clear of the sticky change flag
//   out       - debounced levels
//   rise/fall - one-cycle edge pulses on out
//   pending   - sticky "out changed since last ack" flags
// master drives the raw inputs and controls, slave is the debouncer.
interface debounce_bank_if #(
    parameter int CHANNELS     = 4,
    parameter int COUNTER_BITS = 5
);
    logic [COUNTER_BITS-1:0] threshold;
    logic [CHANNELS-1:0]     in;
    logic [CHANNELS-1:0]     ack;
    logic [CHANNELS-1:0]     out;
    logic [CHANNELS-1:0]     rise;
    logic [CHANNELS-1:0]     fall;
    logic [CHANNELS-1:0]     pending;

    modport master (
        output threshold, in, ack,
        input  out, rise, fall, pending
    );

    modport slave (
        input  threshold, in, ack,
        output out, rise, fall, pending
    );
endinterface

// File: rtl/debounce_bank.sv
// debounce_bank: multi-channel debouncer for slow, noisy board inputs.
// Each channel synchronises its raw input, requires it to disagree with the
// current debounced level on threshold+1 consecutive edges before following
// it, and reports the change as a rise/fall pulse plus a sticky pending flag.
// Ports:
//   clock - rising-edge clock
//   reset - synchronous, active-high reset
//   bus   - debounce_bank_if slave (threshold, in, ack, out, rise, fall, pending)

// One debouncer channel.
module debounce_lane #(
    parameter int   COUNTER_BITS = 5,
    parameter int   SYNC_STAGES  = 2,
    parameter logic RST_VAL      = 1'b0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [COUNTER_BITS-1:0] threshold,
    input  logic                    din,
    input  logic                    ack,
    output logic                    dout,
    output logic                    rise,
    output logic                    fall,
    output logic                    pending
);
    logic [SYNC_STAGES-1:0]  sync;
    logic [COUNTER_BITS-1:0] cnt;
    logic                    s;
    logic                    flip;

    assign s = sync[SYNC_STAGES-1];

    // ">=" rather than "==" so lowering threshold below a running count
    // completes the count on the very next edge. cnt only increments while
    // below threshold, so it can never wrap.
    assign flip = (s != dout) && (cnt >= threshold);

    always_ff @(posedge clock) begin
        if (reset) begin
            sync    <= {SYNC_STAGES{RST_VAL}};
            dout    <= RST_VAL;
            cnt     <= '0;
            rise    <= 1'b0;
            fall    <= 1'b0;
            pending <= 1'b0;
        end else begin
            sync[0] <= din;
            for (int k = 1; k < SYNC_STAGES; k++)
                sync[k] <= sync[k-1];

            if (s == dout)
                cnt <= '0;          // agreement (or glitch ended): restart
            else if (flip) begin
                dout <= s;
                cnt  <= '0;
            end else
                cnt <= cnt + 1'b1;

            // Pulses land in the same cycle the new dout first appears.
            rise <= flip & s;
            fall <= flip & ~s;

            // A change on the same edge as ack keeps the flag set.
            if (flip)
                pending <= 1'b1;
            else if (ack)
                pending <= 1'b0;
        end
    end
endmodule

module debounce_bank #(
    parameter int                    CHANNELS     = 4,
    parameter int                    COUNTER_BITS = 5,
    parameter int                    SYNC_STAGES  = 2,
    parameter logic [CHANNELS-1:0]   RESET_VALUE  = '0
) (
    input  logic           clock,
    input  logic           reset,
    debounce_bank_if.slave bus
);
    logic [CHANNELS-1:0] out_w;
    logic [CHANNELS-1:0] rise_w;
    logic [CHANNELS-1:0] fall_w;
    logic [CHANNELS-1:0] pend_w;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
        debounce_lane #(
            .COUNTER_BITS (COUNTER_BITS),
            .SYNC_STAGES  (SYNC_STAGES),
            .RST_VAL      (RESET_VALUE[i])
        ) u_lane (
            .clock     (clock),
            .reset     (reset),
            .threshold (bus.threshold),
            .din       (bus.in[i]),
            .ack       (bus.ack[i]),
            .dout      (out_w[i]),
            .rise      (rise_w[i]),
            .fall      (fall_w[i]),
            .pending   (pend_w[i])
        );
    end

    assign bus.out     = out_w;
    assign bus.rise    = rise_w;
    assign bus.fall    = fall_w;
    assign bus.pending = pend_w;
endmodule

// File: tb/tb_debounce_bank.sv
// Directed bench for debounce_bank: two instances, one with all-zero reset
// level and one with reset level 4'b1010.
module tb_debounce_bank;
    logic clock;
    logic rst0, rst1;
    int   tests = 0;
    int   fails = 0;
    logic [3:0] ev_rise0, ev_fall0, ev_rise1, ev_fall1, ev_pend1;

    debounce_bank_if #(.CHANNELS(4), .COUNTER_BITS(5)) bus0 ();
    debounce_bank_if #(.CHANNELS(4), .COUNTER_BITS(5)) bus1 ();

    debounce_bank #(.CHANNELS(4), .COUNTER_BITS(5), .SYNC_STAGES(2),
                    .RESET_VALUE(4'b0000))
        dut0 (.clock(clock), .reset(rst0), .bus(bus0));

    debounce_bank #(.CHANNELS(4), .COUNTER_BITS(5), .SYNC_STAGES(2),
                    .RESET_VALUE(4'b1010))
        dut1 (.clock(clock), .reset(rst1), .bus(bus1));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance n edges, sampling 1 time unit after each edge and OR-ing the
    // pulse outputs seen along the way.
    task automatic tick_n(input int n);
        ev_rise0 = '0; ev_fall0 = '0;
        ev_rise1 = '0; ev_fall1 = '0; ev_pend1 = '0;
        repeat (n) begin
            @(posedge clock); #1;
            ev_rise0 |= bus0.rise; ev_fall0 |= bus0.fall;
            ev_rise1 |= bus1.rise; ev_fall1 |= bus1.fall;
            ev_pend1 |= bus1.pending;
        end
    endtask

    task automatic reset0();
        bus0.in = '0; bus0.ack = '0; rst0 = 1'b1;
        tick_n(2);
        rst0 = 1'b0;
    endtask

    task automatic test_reset();
        rst0 = 1'b1; bus0.in = 4'b1111; bus0.ack = '0; bus0.threshold = 5'd0;
        tick_n(2);
        tests++; if (bus0.out !== 4'b0000) begin fails++; $display("FAIL reset_out: got %b want 0000", bus0.out); end
        tests++; if ((ev_rise0 | ev_fall0 | bus0.pending) !== 4'b0000) begin fails++; $display("FAIL reset_events: got %b want 0000", ev_rise0 | ev_fall0 | bus0.pending); end
        bus0.in = '0; rst0 = 1'b0;
        tick_n(4);
        tests++; if ((bus0.out | ev_rise0 | ev_fall0 | bus0.pending) !== 4'b0000) begin fails++; $display("FAIL post_reset_quiet: got %b want 0000", bus0.out | ev_rise0 | ev_fall0 | bus0.pending); end
    endtask

    task automatic test_clean_step();
        reset0(); bus0.threshold = 5'd3; bus0.in = 4'b0001;
        tick_n(5);
        tests++; if ((bus0.out | ev_rise0) !== 4'b0000) begin fails++; $display("FAIL step_early: got %b want 0000", bus0.out | ev_rise0); end
        tick_n(1);
        tests++; if (bus0.out !== 4'b0001) begin fails++; $display("FAIL step_out: got %b want 0001", bus0.out); end
        tests++; if (bus0.rise !== 4'b0001) begin fails++; $display("FAIL step_rise: got %b want 0001", bus0.rise); end
        tests++; if (bus0.pending !== 4'b0001) begin fails++; $display("FAIL step_pending: got %b want 0001", bus0.pending); end
        tick_n(1);
        tests++; if ({bus0.rise, bus0.out} !== 8'b0000_0001) begin fails++; $display("FAIL step_rise_width: got %b want 00000001", {bus0.rise, bus0.out}); end
    endtask

    task automatic test_glitch();
        reset0(); bus0.threshold = 5'd3; bus0.in = 4'b0010;
        tick_n(3);
        bus0.in = 4'b0000;
        tick_n(8);
        tests++; if ({bus0.out, ev_rise0, bus0.pending} !== 12'h000) begin fails++; $display("FAIL glitch_reject: got %h want 000", {bus0.out, ev_rise0, bus0.pending}); end
        bus0.in = 4'b0010;
        tick_n(5);
        tests++; if (bus0.out !== 4'b0000) begin fails++; $display("FAIL glitch_restart_early: got %b want 0000", bus0.out); end
        tick_n(1);
        tests++; if ({bus0.out, bus0.rise} !== 8'b0010_0010) begin fails++; $display("FAIL glitch_restart_out: got %b want 00100010", {bus0.out, bus0.rise}); end
    endtask

    task automatic test_threshold_zero();
        reset0(); bus0.threshold = 5'd0; bus0.in = 4'b0100;
        tick_n(1);
        bus0.in = 4'b0000;
        tick_n(2);
        tests++; if ({bus0.out, bus0.rise, bus0.fall} !== 12'b0100_0100_0000) begin fails++; $display("FAIL thr0_rise: got %b want 010001000000", {bus0.out, bus0.rise, bus0.fall}); end
        tick_n(1);
        tests++; if ({bus0.out, bus0.rise, bus0.fall} !== 12'b0000_0000_0100) begin fails++; $display("FAIL thr0_fall: got %b want 000000000100", {bus0.out, bus0.rise, bus0.fall}); end
    endtask

    task automatic test_threshold_max();
        reset0(); bus0.threshold = 5'd31; bus0.in = 4'b0001;
        tick_n(33);
        tests++; if (bus0.out !== 4'b0000) begin fails++; $display("FAIL thr31_early: got %b want 0000", bus0.out); end
        tick_n(1);
        tests++; if (bus0.out !== 4'b0001) begin fails++; $display("FAIL thr31_out: got %b want 0001", bus0.out); end
    endtask

    task automatic test_threshold_lower();
        reset0(); bus0.threshold = 5'd31; bus0.in = 4'b0001;
        tick_n(12);               // counter now at 10
        tests++; if (bus0.out !== 4'b0000) begin fails++; $display("FAIL lower_early: got %b want 0000", bus0.out); end
        bus0.threshold = 5'd2;
        tick_n(1);
        tests++; if ({bus0.out, bus0.rise} !== 8'b0001_0001) begin fails++; $display("FAIL lower_out: got %b want 00010001", {bus0.out, bus0.rise}); end
    endtask

    task automatic test_pending_ack();
        reset0(); bus0.threshold = 5'd0; bus0.in = 4'b1000;
        tick_n(3);
        tests++; if ({bus0.out, bus0.pending} !== 8'b1000_1000) begin fails++; $display("FAIL pend_set: got %b want 10001000", {bus0.out, bus0.pending}); end
        bus0.ack = 4'b1000;
        tick_n(1);
        bus0.ack = 4'b0000;
        tests++; if (bus0.pending !== 4'b0000) begin fails++; $display("FAIL pend_ack_clear: got %b want 0000", bus0.pending); end
        bus0.in = 4'b0000;
        tick_n(2);
        bus0.ack = 4'b1000;       // same edge as the 1->0 change
        tick_n(1);
        bus0.ack = 4'b0000;
        tests++; if ({bus0.out, bus0.fall, bus0.pending} !== 12'b0000_1000_1000) begin fails++; $display("FAIL pend_ack_collide: got %b want 000010001000", {bus0.out, bus0.fall, bus0.pending}); end
        tick_n(1);
        tests++; if (bus0.pending !== 4'b1000) begin fails++; $display("FAIL pend_hold: got %b want 1000", bus0.pending); end
    endtask

    task automatic test_reset_midcount();
        rst1 = 1'b1; bus1.in = 4'b1010; bus1.ack = '0; bus1.threshold = 5'd5;
        tick_n(2);
        rst1 = 1'b0;
        tests++; if (bus1.out !== 4'b1010) begin fails++; $display("FAIL rv_reset_out: got %b want 1010", bus1.out); end
        bus1.in = 4'b0101;
        tick_n(5);                // counters at 3
        rst1 = 1'b1;
        tick_n(1);
        rst1 = 1'b0;
        tests++; if ({bus1.out, bus1.rise, bus1.fall, bus1.pending} !== 16'hA000) begin fails++; $display("FAIL rv_midreset: got %h want a000", {bus1.out, bus1.rise, bus1.fall, bus1.pending}); end
        tick_n(7);                // count restarts from zero
        tests++; if ({bus1.out, ev_rise1, ev_fall1} !== 12'hA00) begin fails++; $display("FAIL rv_discard: got %h want a00", {bus1.out, ev_rise1, ev_fall1}); end
        tick_n(1);
        tests++; if ({bus1.out, bus1.rise, bus1.fall} !== 12'b0101_0101_1010) begin fails++; $display("FAIL rv_recount: got %b want 010101011010", {bus1.out, bus1.rise, bus1.fall}); end
        rst1 = 1'b1;
        tick_n(1);
        rst1 = 1'b0; bus1.in = 4'b1010;
        tick_n(12);
        tests++; if ({bus1.out, ev_rise1, ev_fall1, ev_pend1} !== 16'hA000) begin fails++; $display("FAIL rv_steady: got %h want a000", {bus1.out, ev_rise1, ev_fall1, ev_pend1}); end
    endtask

    task automatic test_back_to_back();
        reset0(); bus0.threshold = 5'd1; bus0.in = 4'b1111;
        tick_n(3);
        tests++; if ({bus0.out, ev_rise0} !== 8'h00) begin fails++; $display("FAIL multi_early: got %h want 00", {bus0.out, ev_rise0}); end
        tick_n(1);
        tests++; if ({bus0.out, bus0.rise} !== 8'hFF) begin fails++; $display("FAIL multi_rise: got %h want ff", {bus0.out, bus0.rise}); end
        tick_n(1);
        tests++; if ({bus0.out, bus0.rise} !== 8'hF0) begin fails++; $display("FAIL multi_width: got %h want f0", {bus0.out, bus0.rise}); end
    endtask

    initial begin
        rst0 = 1'b1; rst1 = 1'b1;
        bus0.in = '0; bus0.ack = '0; bus0.threshold = '0;
        bus1.in = '0; bus1.ack = '0; bus1.threshold = '0;
        test_reset();
        test_clean_step();
        test_glitch();
        test_threshold_zero();
        test_threshold_max();
        test_threshold_lower();
        test_pending_ack();
        test_reset_midcount();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
